// File: rtl/braille_cell_sequencer.sv
// braille_cell_sequencer: buffers braille cells in a small FIFO and plays
// them out on the dot-actuator bus. Each cell is shown for a programmable
// hold time and then blanked for a programmable gap.
module braille_cell_sequencer #(
  parameter int DOTS   = 6,
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DOTS-1:0]          in_dots,
  input  logic                     enable,
  input  logic [HOLD_W-1:0]        hold_cycles,
  input  logic [HOLD_W-1:0]        gap_cycles,
  output logic [DOTS-1:0]          dots_out,
  output logic                     cell_active,
  output logic                     cell_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Reject cell formats and buffer sizes the tile cannot drive.
  if (!(DOTS == 6 || DOTS == 8)) begin : g_bad_dots
    $error("braille_cell_sequencer: DOTS must be 6 or 8");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("braille_cell_sequencer: DEPTH must be a power of 2 in 2..16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [HOLD_W-1:0]    timer, timer_nx;
  logic [DOTS-1:0]      disp, disp_nx;

  logic [DOTS-1:0]      mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt;

  logic                 push;
  logic                 pop;
  logic                 try_load;
  logic                 last;
  logic [HOLD_W-1:0]    hold_load;

  // Flow control and status are pure decodes of the occupancy count.
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign in_ready = !full && !rst;
  assign count    = cnt;
  assign push     = in_valid && in_ready;

  // A zero hold still shows the cell for one cycle.
  assign hold_load = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
  assign last      = (timer == HOLD_W'(1));

  // Actuators are driven only while a cell is in SHOW, so reset blanks them at once.
  assign dots_out    = (state == SHOW) ? disp : '0;
  assign cell_active = (state == SHOW);
  assign cell_done   = (state == SHOW) && last;

  // Cell storage: written on push, read at the head pointer on pop.
  // NOTE: the storage array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dots;
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel in the count.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sequencer state, cycle timer and display register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      disp  <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      disp  <= disp_nx;
    end
  end

  // Next-state logic: count down SHOW/GAP, then try to start the next cell.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    disp_nx  = disp;
    pop      = 1'b0;
    try_load = 1'b0;

    case (state)
      IDLE: try_load = 1'b1;
      SHOW: begin
        timer_nx = timer - 1'b1;
        if (last) begin
          if (gap_cycles != '0) begin
            timer_nx = gap_cycles;
            state_nx = GAP;
          end else begin
            try_load = 1'b1;
          end
        end
      end
      GAP: begin
        timer_nx = timer - 1'b1;
        if (last) try_load = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    if (try_load) begin
      if (enable && !empty) begin
        pop      = 1'b1;
        disp_nx  = mem[rd_ptr];
        timer_nx = hold_load;
        state_nx = SHOW;
      end else begin
        state_nx = IDLE;
      end
    end
  end

endmodule

// File: doc/braille_cell_sequencer.md
Name: braille_cell_sequencer

Overview:
- Buffers braille dot patterns (one cell per word) in a small FIFO and presents them one at a time on a dot-actuator bus.
- Each cell is held for a programmable number of cycles, then blanked for a programmable gap.
- Parametrised successor to our first braille tile: generalised in dot count (6/8-dot cells) and buffer depth, with timing and flow control added.
- Sits between the host input pins and the actuator/LED driver outputs of the tile.

Parameters:
- DOTS, 6, dots per cell; legal values 6 or 8.
- DEPTH, 4, FIFO depth in cells; power of 2, 2..16.
- HOLD_W, 16, width of the hold/gap cycle counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  host offers a cell.
- in_ready  out  1  FIFO can accept a cell.
- in_dots  in  DOTS  dot pattern; bit i = dot i+1.
- enable  in  1  permits starting new cells.
- hold_cycles  in  HOLD_W  display time per cell.
- gap_cycles  in  HOLD_W  blank time after each cell.
- dots_out  out  DOTS  actuator pattern.
- cell_active  out  1  high while a cell is displayed (SHOW).
- cell_done  out  1  one-cycle pulse on the last SHOW cycle.
- count  out  $clog2(DEPTH)+1  cells stored in the FIFO.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers and count = 0; state = IDLE.
  - dots_out = 0; cell_active = 0; cell_done = 0; empty = 1; full = 0.
  - in_ready = 0 while rst is high.
- Write handshake:
  - in_ready = !full && !rst.
  - A push occurs on a rising edge with in_valid && in_ready.
  - A push while full is impossible, because in_ready is low whenever full, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, SHOW, GAP.
- IDLE:
  - dots_out = 0.
  - If enable && !empty: pop the head into the display register, load timer = max(hold_cycles, 1), go to SHOW.
- SHOW:
  - dots_out = display register; cell_active = 1.
  - The timer decrements each cycle; SHOW lasts exactly max(hold_cycles, 1) cycles.
  - On the last SHOW cycle, cell_done = 1.
  - Exit when gap_cycles != 0: load timer = gap_cycles (sampled on this cycle), go to GAP.
  - Exit when gap_cycles == 0: apply the reload rule below.
- GAP:
  - dots_out = 0; lasts gap_cycles cycles.
  - On the last GAP cycle, apply the reload rule.
- Reload rule (end of SHOW with zero gap, or end of GAP):
  - If enable && !empty: pop the next cell, load the hold timer, go to SHOW. With a zero gap, consecutive cells are back-to-back with no blank cycle.
  - Otherwise go to IDLE.
- Latency:
  - A cell pushed at edge E into an empty FIFO while IDLE and enabled is popped at edge E+1.
  - dots_out shows that cell from E+1 onward.
- hold_cycles is sampled only at load; changing it mid-cell has no effect on the current cell.
- Deasserting enable during SHOW or GAP does not truncate the current cell or its gap. It only blocks the next pop.
- A write arriving while the FIFO drains to empty in the same cycle is accepted. count reflects the net change.
- Asserting rst mid-cell immediately blanks dots_out and discards all buffered cells.
- Unused/illegal DOTS values are a elaboration error (generate-time check).

Test Plan:
- Reset, then push 0x3F (DOTS=6) with hold=3, gap=2, enable=1 -> dots_out=0x3F for exactly 3 cycles starting 1 cycle after the push, then 0 for 2 cycles; cell_done pulses on the 3rd cycle; IDLE afterwards; empty=1.
- enable=0, push 4 cells (0x01, 0x03, 0x07, 0x0F) with DEPTH=4 -> count=4, full=1, in_ready=0; a 5th in_valid is not accepted and count stays 4.
- From the full FIFO, set enable=1, hold=1, gap=0 -> dots_out = 0x01, 0x03, 0x07, 0x0F on 4 consecutive cycles, no blanks; 4 cell_done pulses; then empty=1, dots_out=0.
- hold=0, gap=0, one cell 0x2A -> displayed for exactly 1 cycle (hold clamped to 1).
- Drop enable during SHOW of the first of 2 buffered cells (hold=4, gap=1) -> the first cell completes 4 cycles plus 1 gap; the second cell is not popped; count=1 until enable returns.
- Assert rst during SHOW with 3 cells buffered -> dots_out=0 and count=0 in the same cycle (async); after release, in_ready=1 and no stale cell appears.
- DOTS=8, DEPTH=8 build: push 0xFF and 0x81 -> dots_out is 8 bits wide and shows 0xFF then 0x81 with the programmed timing; count wraps correctly across 10 push/pop cycles.
